// File: rtl/branch_pattern_table.sv
// branch_pattern_table: 2-bit saturating counter table indexed by {pc, local history},
// swept to weak-not-taken after reset, with a write-first bypass on same-cycle update.
module branch_pattern_table #(
    parameter int PC_BITS   = 5,
    parameter int HIST_BITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 lookup_valid,
    input  logic [9:0]           pc,
    input  logic                 read_hit,
    input  logic [HIST_BITS-1:0] read_history,
    input  logic                 we,
    input  logic [9:0]           update_pc,
    input  logic [HIST_BITS-1:0] update_history,
    input  logic                 branch_taken,
    output logic                 predict_valid,
    output logic                 predict_taken,
    output logic                 ready
);
    localparam int IW    = PC_BITS + HIST_BITS;
    localparam int DEPTH = 1 << IW;

    typedef enum logic {INIT, RUN} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic            pv_q, pv_d, pt_q, pt_d;
    logic [1:0]      tbl_q [DEPTH];
    logic [IW-1:0]   lidx, uidx;
    logic [1:0]      cur, nxt;
    logic            upd;
    logic            unused_pc;

    assign unused_pc     = ^{pc[9:PC_BITS], update_pc[9:PC_BITS]};
    assign ready         = state_q == RUN;
    assign predict_valid = pv_q;
    assign predict_taken = pt_q;

    always_comb begin
        lidx    = {pc[PC_BITS-1:0], read_hit ? read_history : '0};
        uidx    = {update_pc[PC_BITS-1:0], update_history};
        cur     = tbl_q[uidx];
        nxt     = branch_taken ? (cur == 2'b11 ? cur : cur + 2'b01)
                               : (cur == 2'b00 ? cur : cur - 2'b01);
        upd     = we && ready;
        state_d = (state_q == INIT && &ptr_q) ? RUN : state_q;
        ptr_d   = state_q == INIT ? ptr_q + 1'b1 : ptr_q;
        pv_d    = lookup_valid && ready;
        // Same-index update wins so the prediction sees the post-update counter.
        pt_d    = pv_d && ((upd && uidx == lidx) ? nxt[1] : tbl_q[lidx][1]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            ptr_q   <= '0;
            pv_q    <= 1'b0;
            pt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pv_q    <= pv_d;
            pt_q    <= pt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT)
            tbl_q[ptr_q] <= 2'b01;
        else if (!rst && upd)
            tbl_q[uidx] <= nxt;
    end
endmodule

// File: doc/branch_pattern_table.md
BRANCH_PATTERN_TABLE -- requirements
Module: branch_pattern_table

Interface
REQ-001 SHALL have parameter PC_BITS, default 5, number of low pc bits used in the table index.
REQ-002 SHALL have parameter HIST_BITS, default 3, local-history width; must equal the history cache output width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; sole clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port lookup_valid  input  1  prediction request this cycle.
REQ-006 SHALL have port pc  input  10  fetch pc of the request.
REQ-007 SHALL have port read_hit  input  1  history cache hit for pc.
REQ-008 SHALL have port read_history  input  HIST_BITS  local history for pc from the history cache.
REQ-009 SHALL have port we  input  1  branch resolved; update table this cycle.
REQ-010 SHALL have port update_pc  input  10  pc of the resolved branch.
REQ-011 SHALL have port update_history  input  HIST_BITS  history used when that branch was predicted.
REQ-012 SHALL have port branch_taken  input  1  actual outcome of the resolved branch.
REQ-013 SHALL have port predict_valid  output  1  predict_taken is valid this cycle.
REQ-014 SHALL have port predict_taken  output  1  predicted direction.
REQ-015 SHALL have port ready  output  1  table initialised; lookups and updates accepted.

Function
REQ-016 SHALL hold 2^(PC_BITS+HIST_BITS) 2-bit saturating counters (256 at defaults); encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-017 SHALL form lookup index {pc[PC_BITS-1:0], hist}, with hist = read_history on read_hit=1 and all-zero on read_hit=0.
REQ-018 SHALL form update index {update_pc[PC_BITS-1:0], update_history}.
REQ-019 SHALL have 1-cycle latency: lookup_valid=1 in cycle N with ready=1 gives predict_valid=1 in cycle N+1, predict_taken = MSB of the indexed counter.
REQ-020 SHALL drive predict_valid=0 in any cycle following a cycle with lookup_valid=0 or ready=0; predict_taken then 0.
REQ-021 SHALL on we=1 with ready=1 read-modify-write the update-index counter in the same cycle: +1 if branch_taken (saturating at 11), -1 otherwise (saturating at 00).
REQ-022 SHALL, when lookup and update indices match in the same cycle, base the prediction on the post-update counter value (write-first bypass).
REQ-023 SHALL accept lookup and update every cycle; no backpressure.
REQ-024 SHALL implement FSM states INIT and RUN; INIT writes 01 to one entry per cycle, indices 0 upward; after the last index it moves to RUN.
REQ-025 SHALL drive ready=1 only in RUN; in INIT, lookups produce no prediction and updates are dropped.

Reset
REQ-026 SHALL on rst=1 enter INIT with sweep pointer 0, ready=0, predict_valid=0, predict_taken=0.
REQ-027 SHALL, with rst deasserted, take exactly 2^(PC_BITS+HIST_BITS) cycles in INIT before ready=1 (256 at defaults).
REQ-028 SHALL restart the sweep from index 0 on rst asserted mid-sweep or in RUN; counters are not cleared by any other means.

Verification
REQ-029 Reset then release -> ready=0 for exactly 256 cycles, then 1; lookups during INIT give predict_valid=0.
REQ-030 After init, lookup pc=10'h004, read_hit=1, read_history=3'b000 -> next cycle predict_valid=1, predict_taken=0.
REQ-031 Two updates update_pc=10'h004, update_history=3'b000, branch_taken=1 -> counter 11, lookup gives predict_taken=1; three more taken stay 11; one not-taken gives 10 (taken); two more not-taken give 00 (not taken).
REQ-032 Same cycle: update taken on index with counter 01 and lookup of that index -> predict_taken=1 next cycle.
REQ-033 Lookup pc=10'h004, read_hit=0, read_history=3'b101 -> uses index of history 000; result matches a hit lookup with history 000, not 101.
REQ-034 Assert rst 100 cycles into INIT -> ready stays 0 for a further full 256 cycles after release; entries written before reset read 01.
